us_arp_tx: RTL

- ARP frame transmitter; counterpart of the ARP receive and ARP table path in the RX stack.
- Serves two request/ack clients:
  - ARP reply: triggered by ARP RX on a valid request for local_ip_addr.
  - ARP request: triggered by the ARP table when dst_ip_addr is unresolved.
- Builds a complete Ethernet+ARP frame and emits it as 64-bit AXI-Stream toward the TX MAC arbiter, honouring tready backpressure.

---
 rtl/us_arp_tx.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/us_arp_tx.sv
// us_arp_tx: ARP frame transmitter.
// Serves an ARP reply client and an ARP request client (reply wins ties),
// latches the addresses at acceptance and streams a complete Ethernet+ARP
// frame as 64-bit AXI-Stream, byte n of each beat on tdata[8n+7:8n].
// Optional feature macro: ARP_TX_PAD_EN pads the frame to 60 bytes
// (8 beats, last tkeep 0x0F). Undefined: 42 bytes (6 beats, last tkeep 0x03).
module us_arp_tx #(
    parameter int GAP_CYCLES = 0
) (
    input  logic        tx_axis_aclk,
    input  logic        tx_axis_aresetn,
    input  logic [47:0] local_mac_addr,
    input  logic [31:0] local_ip_addr,
    input  logic [31:0] dst_ip_addr,
    input  logic [47:0] recv_src_mac_addr,
    input  logic [31:0] recv_src_ip_addr,
    input  logic        arp_reply_req,
    output logic        arp_reply_ack,
    input  logic        arp_request_req,
    output logic        arp_request_ack,
    output logic [63:0] arp_tx_axis_tdata,
    output logic [7:0]  arp_tx_axis_tkeep,
    output logic        arp_tx_axis_tvalid,
    output logic        arp_tx_axis_tlast,
    output logic        arp_tx_axis_tuser,
    input  logic        arp_tx_axis_tready
);

`ifdef ARP_TX_PAD_EN
    localparam logic [2:0] LAST_BEAT = 3'd7;
    localparam logic [7:0] LAST_KEEP = 8'h0F;
`else
    localparam logic [2:0] LAST_BEAT = 3'd5;
    localparam logic [7:0] LAST_KEEP = 8'h03;
`endif
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t      state, next_state;
    logic [2:0]  beat;
    logic [7:0]  gap_cnt;
    logic        load_reply, load_request;
    logic        last_beat;
    logic        is_request_q;
    logic [47:0] dst_mac_q, src_mac_q, tha_q;
    logic [31:0] src_ip_q, tpa_q;
    logic [511:0] frame;

    assign last_beat = (beat == LAST_BEAT);

    // Next-state and client-acceptance decode.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        next_state   = state;
        load_reply   = 1'b0;
        load_request = 1'b0;
        case (state)
            S_IDLE: begin
                if (arp_reply_req) begin
                    load_reply = 1'b1;
                    next_state = S_SEND;
                end else if (arp_request_req) begin
                    load_request = 1'b1;
                    next_state   = S_SEND;
                end
            end
            S_SEND: begin
                if (arp_tx_axis_tready && last_beat)
                    next_state = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST)
                    next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
        if (!tx_axis_aresetn)
            state <= S_IDLE;
        else
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= next_state;
    end

    // Beat/gap counters, ack pulses and the latched frame fields.
    always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
        if (!tx_axis_aresetn) begin
            // NOTE: the frame field registers are reset too; they are few and it keeps reset outputs deterministic.
            beat            <= '0;
            gap_cnt         <= '0;
            arp_reply_ack   <= 1'b0;
            arp_request_ack <= 1'b0;
            is_request_q    <= 1'b0;
            dst_mac_q       <= '0;
            src_mac_q       <= '0;
            tha_q           <= '0;
            src_ip_q        <= '0;
            tpa_q           <= '0;
        end else begin
            arp_reply_ack   <= load_reply;
            arp_request_ack <= load_request;

            if (load_reply || load_request)
                beat <= '0;
            else if (state == S_SEND && arp_tx_axis_tready)
                beat <= last_beat ? 3'd0 : beat + 3'd1;

            if (state == S_SEND)
                gap_cnt <= '0;
            else if (state == S_GAP)
                gap_cnt <= gap_cnt + 8'd1;

            if (load_reply || load_request) begin
                src_mac_q    <= local_mac_addr;
                src_ip_q     <= local_ip_addr;
                is_request_q <= load_request;
            end
            if (load_reply) begin
                dst_mac_q <= recv_src_mac_addr;
                tha_q     <= recv_src_mac_addr;
                tpa_q     <= recv_src_ip_addr;
            end else if (load_request) begin
                dst_mac_q <= 48'hFFFF_FFFF_FFFF;
                tha_q     <= '0;
                tpa_q     <= dst_ip_addr;
            end
        end
    end

    // Whole frame image in wire order, byte i at frame[8i+7:8i]; network-order fields.
    always_comb begin
        frame = '0;
        for (int i = 0; i < 6; i++) begin
            frame[8*i      +: 8] = dst_mac_q[8*(5-i) +: 8];
            frame[8*(6+i)  +: 8] = src_mac_q[8*(5-i) +: 8];
            frame[8*(22+i) +: 8] = src_mac_q[8*(5-i) +: 8];
            frame[8*(32+i) +: 8] = tha_q[8*(5-i) +: 8];
        end
        for (int i = 0; i < 4; i++) begin
            frame[8*(28+i) +: 8] = src_ip_q[8*(3-i) +: 8];
            frame[8*(38+i) +: 8] = tpa_q[8*(3-i) +: 8];
        end
        frame[8*12 +: 8] = 8'h08;
        frame[8*13 +: 8] = 8'h06;
        frame[8*14 +: 8] = 8'h00;
        frame[8*15 +: 8] = 8'h01;
        frame[8*16 +: 8] = 8'h08;
        frame[8*17 +: 8] = 8'h00;
        frame[8*18 +: 8] = 8'h06;
        frame[8*19 +: 8] = 8'h04;
        frame[8*20 +: 8] = 8'h00;
        frame[8*21 +: 8] = is_request_q ? 8'h01 : 8'h02;
    end

    // Stream outputs are purely a function of state, so they hold while stalled.
    assign arp_tx_axis_tvalid = (state == S_SEND);
    assign arp_tx_axis_tdata  = arp_tx_axis_tvalid ? frame[{beat, 6'b0} +: 64] : 64'd0;
    assign arp_tx_axis_tkeep  = !arp_tx_axis_tvalid ? 8'h00 : (last_beat ? LAST_KEEP : 8'hFF);
    assign arp_tx_axis_tlast  = arp_tx_axis_tvalid && last_beat;
    assign arp_tx_axis_tuser  = 1'b0;

endmodule
